pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, minimum 1.
REQ-002 Parameter STAGES, default 2: number of register stages, minimum 1.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  global advance enable; low freezes all state.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  pipe accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid item.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  payload of the last stage.
REQ-012 flush  input  1  discard all in-flight items (see Configuration).
REQ-013 count  output  $clog2(STAGES+1)  number of valid stages.

Function
REQ-014 Stage k holds {valid_k, data_k}; stage 0 is input-side, stage STAGES-1 drives out_valid/out_data.
REQ-015 Transfer in: in_valid && in_ready at posedge; transfer out: out_valid && out_ready at posedge.
REQ-016 Last stage advances when enable && (!valid_last || out_ready); stage k<STAGES-1 advances when enable && (!valid_k || stage k+1 advances).
REQ-017 in_ready = stage 0 advance condition, combinational; no combinational path from in_valid to in_ready.
REQ-018 Advancing stage loads valid/data of its predecessor (stage 0 loads in_valid/in_data); a non-advancing stage holds.
REQ-019 Latency: item accepted at edge N is at out_data after edge N+STAGES-1 with no backpressure; throughput one item/cycle.
REQ-020 Full (all valid) with out_ready low: in_ready=0, all stages hold, out_data stable.
REQ-021 Full with out_ready high: simultaneous in and out transfer allowed; count unchanged.
REQ-022 Empty pipe: out_valid=0, count=0, in_ready=enable.
REQ-023 enable low: in_ready=0, no stage changes, out_valid/out_data held; out_ready ignored (no transfer out).
REQ-024 count = popcount of valid bits, registered-state derived, range 0..STAGES; items order-preserved, never duplicated or dropped.
REQ-025 out_data while out_valid=0 is don't-care for consumers but SHALL equal last-stage register contents.

Reset
REQ-026 reset high at posedge: all valid bits 0, all data registers 0, regardless of enable, flush or handshakes.
REQ-027 After reset: out_valid=0, out_data=0, count=0, in_ready=enable.
REQ-028 Reset mid-stream: all in-flight items lost; no transfer in or out counted on the reset edge.

Configuration
REQ-029 Macro PIPE_REG_FLUSH_EN: defined -> flush high at posedge clears all valid bits (data regs hold), in_ready=0 and out_valid forced 0 that cycle, so no transfer; reset has priority over flush; flush works even with enable low.
REQ-030 Macro undefined -> flush port present but ignored; behaviour as if flush=0.

Verification
REQ-031 WIDTH=8, STAGES=3, reset then stream 0x11,0x22,0x33 with out_ready=1 -> 0x11 at out after 3rd edge, then one item per cycle, count peaks at 3.
REQ-032 Fill 3 items with out_ready=0 -> count=3, in_ready=0, out_data=0x11 stable; raise out_ready with in_valid=1 data 0x44 -> count stays 3, order 0x11,0x22,0x33,0x44.
REQ-033 Full pipe, enable=0 for 4 cycles with out_ready=1 -> no output transfers, count=3 throughout; enable=1 resumes in order.
REQ-034 PIPE_REG_FLUSH_EN defined, count=2, flush=1 with in_valid=1 data 0x55 -> next cycle count=0, out_valid=0, 0x55 never emerges; undefined build -> flush ignored, count=3.
REQ-035 reset asserted with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, out_data=0.
REQ-036 STAGES=1, WIDTH=1 -> back-to-back 1,0,1 with out_ready=1 passes at one item/cycle, latency 1 edge.

Source files
------------

// File: rtl/pipe_reg.sv
// ============================================================================
// Module   : pipe_reg
// Purpose  : Valid/ready register pipeline of STAGES stages; optional flush
//            enabled by defining macro PIPE_REG_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          flush,
  output logic [$clog2(STAGES+1)-1:0]   count
);

  localparam int CNT_W = $clog2(STAGES+1);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] stage_adv;
  logic              gap;
  logic              flush_act;
  logic [CNT_W-1:0]  cnt_sum;

`ifdef PIPE_REG_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  // A stage advances when any stage at or beyond it has a hole, or the
  // consumer takes the last item; unrolled this way to avoid a bit-level
  // combinational chain through stage_adv itself.
  always_comb begin
    gap       = out_ready;
    stage_adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      gap          = gap | ~valid_q[k];
      stage_adv[k] = enable & gap;
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
    end
    if (flush_act) begin
      valid_d = '0;
    end else begin
      if (stage_adv[0]) begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_adv[k]) begin
          valid_d[k] = valid_q[k-1];
          data_d[k]  = data_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    cnt_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      cnt_sum = cnt_sum + CNT_W'(valid_q[k]);
    end
  end

  assign count     = cnt_sum;
  assign in_ready  = stage_adv[0] & ~flush_act;
  assign out_valid = valid_q[STAGES-1] & ~flush_act;
  assign out_data  = data_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg.sv
// ============================================================================
// Module   : tb_pipe_reg
// Purpose  : Vector table plus scoreboard bench for pipe_reg (3-stage and
//            1-stage instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg;

`ifdef PIPE_REG_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       clk;
  logic       reset, enable, in_valid, out_ready, flush;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;

  logic       r1_reset, r1_enable, r1_in_valid, r1_out_ready, r1_flush;
  logic [0:0] r1_in_data;
  logic       r1_in_ready, r1_out_valid;
  logic [0:0] r1_out_data;
  logic [0:0] r1_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [$];

  typedef struct {
    logic       rst, en, iv;
    logic [7:0] din;
    logic       ordy, fl;
    logic [1:0] cnt;
    logic       ov;
    logic [7:0] od;
    logic       ir;
  } vec_t;

  vec_t vt [$];

  pipe_reg #(.WIDTH(8), .STAGES(3)) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .count(count)
  );

  pipe_reg #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(r1_reset), .enable(r1_enable),
    .in_valid(r1_in_valid), .in_ready(r1_in_ready), .in_data(r1_in_data),
    .out_valid(r1_out_valid), .out_ready(r1_out_ready), .out_data(r1_out_data),
    .flush(r1_flush), .count(r1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic iv, input logic [7:0] din,
                     input logic ordy, input logic fl, input logic [1:0] cnt,
                     input logic ov, input logic [7:0] od, input logic ir);
    vec_t v;
    v.rst = rst; v.en = en; v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
    v.cnt = cnt; v.ov = ov; v.od = od; v.ir = ir;
    vt.push_back(v);
  endtask

  // Drive one vector, run the scoreboard on the pre-edge handshake, clock it.
  task automatic apply(input vec_t v);
    logic [7:0] exp;
    reset = v.rst; enable = v.en; in_valid = v.iv; in_data = v.din;
    out_ready = v.ordy; flush = v.fl;
    #2;
    if (!reset && out_valid && out_ready && enable) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        chk("sb_out_data", {24'h0, out_data}, {24'h0, exp});
      end
    end
    if (!reset && in_valid && in_ready) sb.push_back(in_data);
    if (reset) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic rst, input logic iv, input logic d, input logic ordy);
    r1_reset = rst; r1_in_valid = iv; r1_in_data = d; r1_out_ready = ordy;
    #2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; flush = 1'b0;
    r1_reset = 1'b1; r1_enable = 1'b1; r1_in_valid = 1'b0; r1_in_data = 1'b0;
    r1_out_ready = 1'b0; r1_flush = 1'b0;

    //   rst en iv din   or fl   cnt ov od     ir
    add(1, 1, 0, 8'h00, 1, 0,   0, 0, 8'h00, 1);
    add(0, 1, 1, 8'h11, 1, 0,   1, 0, 8'h00, 1);
    add(0, 1, 1, 8'h22, 1, 0,   2, 0, 8'h00, 1);
    add(0, 1, 1, 8'h33, 1, 0,   3, 1, 8'h11, 1);
    add(0, 1, 0, 8'h00, 1, 0,   2, 1, 8'h22, 1);
    add(0, 1, 0, 8'h00, 1, 0,   1, 1, 8'h33, 1);
    add(0, 1, 0, 8'h00, 1, 0,   0, 0, 8'h00, 1);
    add(0, 1, 1, 8'h11, 0, 0,   1, 0, 8'h00, 1);
    add(0, 1, 1, 8'h22, 0, 0,   2, 0, 8'h00, 1);
    add(0, 1, 1, 8'h33, 0, 0,   3, 1, 8'h11, 0);
    add(0, 1, 1, 8'h44, 0, 0,   3, 1, 8'h11, 0);
    add(0, 1, 1, 8'h44, 1, 0,   3, 1, 8'h22, 1);
    add(0, 1, 0, 8'h00, 1, 0,   2, 1, 8'h33, 1);
    add(0, 1, 1, 8'h55, 0, 0,   3, 1, 8'h33, 0);
    add(0, 1, 1, 8'h66, 0, 0,   3, 1, 8'h33, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'h77, 1, 0, 3, 1, 8'h33, 0);
    add(0, 1, 0, 8'h00, 1, 0,   2, 1, 8'h44, 1);
    add(0, 1, 0, 8'h00, 1, 0,   1, 1, 8'h55, 1);
    add(0, 1, 0, 8'h00, 1, 0,   0, 0, 8'h00, 1);
    add(0, 1, 1, 8'hAA, 0, 0,   1, 0, 8'h00, 1);
    add(0, 1, 1, 8'hBB, 0, 0,   2, 0, 8'h00, 1);
    add(0, 1, 1, 8'hCC, 0, 0,   3, 1, 8'hAA, 0);
    add(1, 1, 1, 8'hDD, 1, 0,   0, 0, 8'h00, 1);
    add(0, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0);
    add(0, 1, 1, 8'h12, 0, 0,   1, 0, 8'h00, 1);
    add(0, 1, 1, 8'h34, 0, 0,   2, 0, 8'h00, 1);
    add(0, 1, 1, 8'h55, 0, 1,   FL ? 2'd0 : 2'd3, FL ? 1'b0 : 1'b1, FL ? 8'h00 : 8'h12, 0);
    add(0, 1, 0, 8'h00, 1, 0,   FL ? 2'd0 : 2'd2, FL ? 1'b0 : 1'b1, FL ? 8'h12 : 8'h34, 1);
    add(0, 1, 0, 8'h00, 1, 0,   FL ? 2'd0 : 2'd1, FL ? 1'b0 : 1'b1, FL ? 8'h34 : 8'h55, 1);
    add(0, 1, 0, 8'h00, 1, 0,   0, 0, 8'h00, 1);
    add(0, 1, 1, 8'h77, 0, 0,   1, 0, 8'h00, 1);
    add(0, 0, 0, 8'h00, 0, 1,   FL ? 2'd0 : 2'd1, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 1, 0,   FL ? 2'd0 : 2'd1, 0, 8'h00, 1);
    add(0, 1, 0, 8'h00, 1, 0,   FL ? 2'd0 : 2'd1, FL ? 1'b0 : 1'b1, 8'h77, 1);
    add(0, 1, 0, 8'h00, 1, 0,   0, 0, 8'h00, 1);

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i]);
      chk($sformatf("count[%0d]", i),     {30'h0, count},    {30'h0, vt[i].cnt});
      chk($sformatf("out_valid[%0d]", i), {31'h0, out_valid}, {31'h0, vt[i].ov});
      chk($sformatf("out_data[%0d]", i),  {24'h0, out_data},  {24'h0, vt[i].od});
      chk($sformatf("in_ready[%0d]", i),  {31'h0, in_ready},  {31'h0, vt[i].ir});
    end
    chk("sb_drained", sb.size(), 0);

    // Single-stage instance: one-edge latency, one item per cycle.
    step1(1, 0, 1'b0, 1);
    chk("s1_reset_count", {31'h0, r1_count}, 0);
    chk("s1_reset_ready", {31'h0, r1_in_ready}, 1);
    step1(0, 1, 1'b1, 1);
    chk("s1_v0", {31'h0, r1_out_valid}, 1);
    chk("s1_d0", {31'h0, r1_out_data}, 1);
    chk("s1_rdy0", {31'h0, r1_in_ready}, 1);
    step1(0, 1, 1'b0, 1);
    chk("s1_v1", {31'h0, r1_out_valid}, 1);
    chk("s1_d1", {31'h0, r1_out_data}, 0);
    chk("s1_rdy1", {31'h0, r1_in_ready}, 1);
    step1(0, 1, 1'b1, 1);
    chk("s1_v2", {31'h0, r1_out_valid}, 1);
    chk("s1_d2", {31'h0, r1_out_data}, 1);
    step1(0, 0, 1'b1, 1);
    chk("s1_drain_valid", {31'h0, r1_out_valid}, 0);
    chk("s1_drain_count", {31'h0, r1_count}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
